// File: rtl/bus_master_if_pkg.sv
// Shared bus constants and master-side FSM state codes.
package bus_master_if_pkg;

    localparam int unsigned STATE_WIDTH = 2;
    localparam int unsigned BUS_ADDR_W  = 30;
    localparam int unsigned BUS_DATA_W  = 32;

    // Arbiter handshake polarities
    localparam logic REQ_ENABLE    = 1'b1;
    localparam logic REQ_DISABLE   = 1'b0;
    localparam logic GRANT_ENABLE  = 1'b1;
    localparam logic GRANT_DISABLE = 1'b0;

    typedef enum logic [STATE_WIDTH-1:0] {
        BmIdle   = 2'd0,
        BmReq    = 2'd1,
        BmAccess = 2'd2,
        BmDone   = 2'd3
    } bm_state_e;

endpackage

// File: rtl/bus_master_if.sv
// Initiator-side bus interface: arbitrates for the shared bus, runs one access,
// returns read data or reports a timeout to the owning master.
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int unsigned ADDR_W  = BUS_ADDR_W,
    parameter int unsigned DATA_W  = BUS_DATA_W,
    parameter int unsigned TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              err,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic              bus_as,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy
);

    localparam int unsigned      CNT_W    = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

    bm_state_e         state_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [CNT_W-1:0]  tmo_cnt_q;
    logic              flush_seen_q;
    logic              err_q;
    logic              in_access;

    // FSM, request latches, timeout counter and registered completion outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BmIdle;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            rd_data_q    <= '0;
            tmo_cnt_q    <= '0;
            flush_seen_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                BmIdle: begin
                    if (req && !flush) begin
                        state_q   <= BmReq;
                        rw_q      <= rw;
                        addr_q    <= addr;
                        wr_data_q <= wr_data;
                    end
                end
                BmReq: begin
                    if (flush) begin
                        state_q <= BmIdle;
                    end else if (bus_grant == GRANT_ENABLE) begin
                        state_q      <= BmAccess;
                        tmo_cnt_q    <= '0;
                        flush_seen_q <= 1'b0;
                    end
                end
                BmAccess: begin
                    // The slave has committed, so a flush only hides the completion
                    if (flush) begin
                        flush_seen_q <= 1'b1;
                    end
                    if (bus_rdy) begin
                        if (!rw_q) begin
                            rd_data_q <= bus_rd_data;
                        end
                        state_q <= (flush || flush_seen_q) ? BmIdle : BmDone;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= BmIdle;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
                BmDone: begin
                    if (!stall) begin
                        state_q <= BmIdle;
                    end
                end
                default: state_q <= BmIdle;
            endcase
        end
    end

    assign in_access = (state_q == BmAccess);

    // Busy in IDLE is gated by reset so every output reads 0 while reset is held
    assign busy        = reset && ((state_q == BmIdle) ? (req && !flush) : (state_q != BmDone));
    assign done        = (state_q == BmDone);
    assign rd_data     = rd_data_q;
    assign err         = err_q;
    assign bus_req     = (state_q == BmReq || in_access) ? REQ_ENABLE : REQ_DISABLE;
    assign bus_as      = in_access;
    // Bus fields are zeroed outside ACCESS so masters can be OR-combined
    assign bus_rw      = in_access && rw_q;
    assign bus_addr    = in_access ? addr_q : '0;
    assign bus_wr_data = in_access ? wr_data_q : '0;

endmodule
